// File: rtl/drm_sdpram_pkg.sv
// rtl/drm_sdpram_pkg.sv - shared clear-state type and lane-count helper for drm_sdpram
package drm_sdpram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  function automatic int be_width(input int data_width, input int byte_size);
    return data_width / byte_size;
  endfunction

endpackage

// File: rtl/drm_sdpram_clr_ctrl.sv
// rtl/drm_sdpram_clr_ctrl.sv - clear FSM that owns the RAM write port until every word holds INIT_VALUE
module drm_sdpram_clr_ctrl
  import drm_sdpram_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 36,
  parameter int BE_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [BE_WIDTH-1:0]   wr_byte_en,
  output logic [BE_WIDTH-1:0]   mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  init_done
);

  clr_state_e            state;
  logic [ADDR_WIDTH-1:0] cnt;

  // The counter wraps to 0 on the last address, so it can never point outside the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else if (state == CLEAR) begin
      cnt <= cnt + ADDR_WIDTH'(1);
      if (cnt == '1) begin
        state <= READY;
      end
    end
  end

  always_comb begin
    if (state == CLEAR) begin
      mem_we   = '1;
      mem_addr = cnt;
      mem_data = INIT_VALUE;
    end else begin
      mem_we   = wr_en ? wr_byte_en : '0;
      mem_addr = wr_addr;
      mem_data = wr_data;
    end
  end

  assign init_done = (state == READY);

endmodule

// File: rtl/drm_sdpram_param.sv
// rtl/drm_sdpram_param.sv - simple dual-port RAM with byte lanes, self-clear and optional output register
// Define DRM_SDPRAM_BYPASS_EN for write-first per-lane collision data; default build is read-first.
module drm_sdpram_param
  import drm_sdpram_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 36,
  parameter int BYTE_SIZE = 9,
  parameter int OUTPUT_REG = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int BE_WIDTH = be_width(DATA_WIDTH, BYTE_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [BE_WIDTH-1:0]   wr_byte_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  init_done
);

  logic [BE_WIDTH-1:0]   mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  rd_accept;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] stage1;
  logic                  v1;

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH) - 1];

  drm_sdpram_clr_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .BE_WIDTH  (BE_WIDTH),
    .INIT_VALUE(INIT_VALUE)
  ) u_clr_ctrl (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_byte_en(wr_byte_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .init_done (init_done)
  );

  assign rd_accept = rd_en & init_done;

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (mem_we[i]) begin
        mem[mem_addr][i*BYTE_SIZE +: BYTE_SIZE] <= mem_data[i*BYTE_SIZE +: BYTE_SIZE];
      end
    end
  end

  // Read register only moves on an accepted read, which is what makes rd_data hold between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_q <= '0;
      v1    <= 1'b0;
    end else begin
      v1 <= rd_accept;
      if (rd_accept) begin
        ram_q <= mem[rd_addr];
      end
    end
  end

`ifdef DRM_SDPRAM_BYPASS_EN
  logic [BE_WIDTH-1:0]   byp_be;
  logic [DATA_WIDTH-1:0] byp_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_be   <= '0;
      byp_data <= '0;
    end else if (rd_accept) begin
      byp_be   <= (mem_addr == rd_addr) ? mem_we : '0;
      byp_data <= mem_data;
    end
  end

  always_comb begin
    stage1 = ram_q;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (byp_be[i]) begin
        stage1[i*BYTE_SIZE +: BYTE_SIZE] = byp_data[i*BYTE_SIZE +: BYTE_SIZE];
      end
    end
  end
`else
  assign stage1 = ram_q;
`endif

  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] out_q;
      logic                  v2;

      always_ff @(posedge clk) begin
        if (rst) begin
          out_q <= '0;
          v2    <= 1'b0;
        end else begin
          v2 <= v1;
          if (v1) begin
            out_q <= stage1;
          end
        end
      end

      assign rd_data  = out_q;
      assign rd_valid = v2;
    end else begin : g_noreg
      assign rd_data  = stage1;
      assign rd_valid = v1;
    end
  endgenerate

endmodule

// File: tb/tb_drm_sdpram_param.sv
// tb/tb_drm_sdpram_param.sv - randomized and directed bench for drm_sdpram_param, latency 1 and 2 instances
module tb_drm_sdpram_param;

  localparam logic [35:0] INIT = 36'h5A3C96E17;
`ifdef DRM_SDPRAM_BYPASS_EN
  localparam logic [35:0] COLL_EXP = 36'hAAAAAAAAA;
`else
  localparam logic [35:0] COLL_EXP = 36'h111111111;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [35:0] wr_data;
  logic [3:0]  wr_byte_en;
  logic        rd_en;
  logic [6:0]  rd_addr;
  logic [35:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1;
  logic        init_done0, init_done1;

  always #5 clk = ~clk;

  drm_sdpram_param #(
    .ADDR_WIDTH(7), .DATA_WIDTH(36), .BYTE_SIZE(9), .OUTPUT_REG(0), .INIT_VALUE(INIT)
  ) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_byte_en(wr_byte_en), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .init_done(init_done0)
  );

  drm_sdpram_param #(
    .ADDR_WIDTH(7), .DATA_WIDTH(36), .BYTE_SIZE(9), .OUTPUT_REG(1), .INIT_VALUE(INIT)
  ) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_byte_en(wr_byte_en), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .init_done(init_done1)
  );

  int checks = 0;
  int errors = 0;

  // Reference: the memory contents, plus a per-edge log of read results that each latency taps.
  logic [35:0] ref_mem [0:127];
  logic        hv [0:4095];
  logic [35:0] hd [0:4095];
  logic [35:0] hold0, hold1;
  int          n = 0;
  int          last_rst = 0;

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [35:0] d;
    logic        e_done;
    @(posedge clk);
    n++;
    hv[n] = 1'b0;
    hd[n] = '0;
    if (rst) begin
      last_rst = n;
      for (int a = 0; a < 128; a++) ref_mem[a] = INIT;
    end else if (n >= last_rst + 129) begin
      if (rd_en) begin
        d = ref_mem[rd_addr];
`ifdef DRM_SDPRAM_BYPASS_EN
        if (wr_en && wr_addr == rd_addr)
          for (int i = 0; i < 4; i++)
            if (wr_byte_en[i]) d[i*9 +: 9] = wr_data[i*9 +: 9];
`endif
        hv[n] = 1'b1;
        hd[n] = d;
      end
      if (wr_en)
        for (int i = 0; i < 4; i++)
          if (wr_byte_en[i]) ref_mem[wr_addr][i*9 +: 9] = wr_data[i*9 +: 9];
    end
    e_done = !rst && (n >= last_rst + 128);
    #1;
    if (rst) begin
      hold0 = '0;
      hold1 = '0;
    end else begin
      if (hv[n]) hold0 = hd[n];
      if (hv[n-1]) hold1 = hd[n-1];
    end
    check("rd_valid_l1", 36'(rd_valid0), rst ? 36'd0 : 36'(hv[n]));
    check("rd_valid_l2", 36'(rd_valid1), rst ? 36'd0 : 36'(hv[n-1]));
    check("rd_data_l1", rd_data0, hold0);
    check("rd_data_l2", rd_data1, hold1);
    check("init_done_l1", 36'(init_done0), 36'(e_done));
    check("init_done_l2", 36'(init_done1), 36'(e_done));
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    int          done_cyc;
    logic [11:0] m0, m1;
    logic [63:0] r;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_byte_en = '0;
    rd_en = 1'b0; rd_addr = '0;
    repeat (3) step();

    // Clear with a write and reads held active; both must be ignored.
    rst = 1'b0; wr_en = 1'b1; wr_addr = 7'd5; wr_data = 36'h123456789; wr_byte_en = 4'hF;
    rd_en = 1'b1; rd_addr = 7'd5;
    done_cyc = 0;
    for (int c = 1; c <= 300 && done_cyc == 0; c++) begin
      step();
      if (init_done0) done_cyc = c + 1;
    end
    check("init_cycles", 36'(done_cyc), 36'd129);
    idle();

    for (int a = 0; a < 128; a++) begin
      rd_en = 1'b1; rd_addr = 7'(a); step();
    end
    idle(); step(); step();
    rd_en = 1'b1; rd_addr = 7'd5; step();
    check("addr5_after_clear", rd_data0, INIT);
    idle(); step();

    // Byte-lane masking.
    wr_en = 1'b1; wr_addr = 7'd3; wr_data = 36'hFFFFFFFFF; wr_byte_en = 4'hF; step();
    wr_data = 36'h0; wr_byte_en = 4'b0101; step();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 7'd3; step();
    check("lane_mask_l1", rd_data0, 36'hFF803FE00);
    idle(); step();
    check("lane_mask_l2", rd_data1, 36'hFF803FE00);

    // Same-address collision.
    wr_en = 1'b1; wr_addr = 7'd10; wr_data = 36'h111111111; wr_byte_en = 4'hF; step();
    wr_data = 36'hAAAAAAAAA; rd_en = 1'b1; rd_addr = 7'd10; step();
    check("collide_first", rd_data0, COLL_EXP);
    wr_en = 1'b0; step();
    check("collide_second", rd_data0, 36'hAAAAAAAAA);
    idle(); step(); step();

    // Back-to-back reads: valid windows per latency.
    m0 = '0; m1 = '0;
    for (int j = 1; j <= 11; j++) begin
      rd_en = (j <= 8); rd_addr = 7'(j - 1);
      step();
      m0[j] = rd_valid0;
      m1[j] = rd_valid1;
    end
    check("b2b_window_l1", 36'(m0), 36'h1FE);
    check("b2b_window_l2", 36'(m1), 36'h3FC);
    idle(); step();

    // Random traffic on a narrow address range so collisions are frequent.
    for (int k = 0; k < 600; k++) begin
      r = {$urandom(), $urandom()};
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = 7'($urandom_range(0, 15));
      wr_data = r[35:0];
      wr_byte_en = 4'($urandom_range(0, 15));
      rd_en = 1'($urandom_range(0, 1));
      rd_addr = 7'($urandom_range(0, 15));
      step();
    end

    // Reset with reads in flight, then reset again part-way through the clear.
    idle();
    for (int k = 0; k < 3; k++) begin
      rd_en = 1'b1; rd_addr = 7'($urandom_range(0, 15)); step();
    end
    rst = 1'b1; step();
    rst = 1'b0; rd_en = 1'b1;
    for (int k = 0; k < 60; k++) step();
    rst = 1'b1; step();
    rst = 1'b0;
    done_cyc = 0;
    for (int c = 1; c <= 300 && done_cyc == 0; c++) begin
      step();
      if (init_done0) done_cyc = c + 1;
    end
    check("reinit_cycles", 36'(done_cyc), 36'd129);
    idle();
    for (int a = 0; a < 128; a++) begin
      rd_en = 1'b1; rd_addr = 7'(a); step();
    end
    idle(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
